// File: rtl/scope_lcd_pkg.sv
// Shared definitions for the scope_info <-> character-LCD path.
// Holds the frame geometry, the state encoding used by the byte reader
// (also exposed on its debug port) and the ASCII space substitute.
package scope_lcd_pkg;

  localparam int SCOPE_INFO_BYTES         = 16;
  localparam int SCOPE_INFO_BITS_PER_BYTE = 8;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SNAPSHOT = 4'd1,
    ISSUE    = 4'd2,
    GAP      = 4'd3,
    DONE     = 4'd4
  } state_t;

endpackage

// File: rtl/scope_ack_timer.sv
// Ack-wait counter for the LCD byte reader.
// Ports:
//   sm_clk  - clock, rising edge
//   reset   - synchronous, active-low
//   clr     - zero the count (wins over en)
//   en      - count up one per cycle
//   tc      - terminal count: the count is about to reach all-ones this
//             cycle, i.e. en has been high for 2**ack_timeout_bits-1
//             consecutive cycles since the last clear
module scope_ack_timer #(
  parameter int ack_timeout_bits = 8
) (
  input  logic sm_clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [ack_timeout_bits-1:0] TC_VAL =
    {{(ack_timeout_bits-1){1'b1}}, 1'b0};

  logic [ack_timeout_bits-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en)
      count_d = count_q + 1'b1;
  end

  // Gated by ~clr so a clear in the same cycle (ack) suppresses the timeout.
  assign tc = en & ~clr & (count_q == TC_VAL);

  always_ff @(posedge sm_clk) begin
    if (!reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/scope_lcd_byte_reader.sv
// Streams a snapshot of the scope_info register bank to a character-LCD
// write port, highest byte index first (lands at column 0).
// Ports:
//   sm_clk, reset    - clock; synchronous active-low reset
//   start            - request one frame, sampled only in IDLE
//   scope_info_flat  - byte i at bits [8i+7:8i]
//   lcd_ack          - downstream accepted the current byte
//   lcd_req          - lcd_data/lcd_addr valid
//   lcd_data         - byte being written
//   lcd_addr         - LCD column = scope_info_bytes-1-index
//   busy             - not IDLE
//   finish           - one-cycle pulse at end of frame (done or aborted)
//   error            - sticky ack timeout flag, cleared by an accepted start
//   debug            - [3:0] state, [7:4] index, [8] error, [15:9] zero
// Build option: SCOPE_READER_NULL_TO_SPACE_EN - drive 8'h00 bytes as an
// ASCII space on lcd_data (snapshot and debug untouched).
module scope_lcd_byte_reader
  import scope_lcd_pkg::*;
#(
  parameter int scope_info_bytes         = SCOPE_INFO_BYTES,
  parameter int scope_info_bits_per_byte = SCOPE_INFO_BITS_PER_BYTE,
  parameter int scope_info_counter_bits  = 4,
  parameter int ack_timeout_bits         = 8
) (
  input  logic                                                 sm_clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic [scope_info_bytes*scope_info_bits_per_byte-1:0] scope_info_flat,
  input  logic                                                 lcd_ack,
  output logic                                                 lcd_req,
  output logic [scope_info_bits_per_byte-1:0]                  lcd_data,
  output logic [scope_info_counter_bits-1:0]                   lcd_addr,
  output logic                                                 busy,
  output logic                                                 finish,
  output logic                                                 error,
  output logic [15:0]                                          debug
);

  localparam int FLAT_W = scope_info_bytes * scope_info_bits_per_byte;
  localparam logic [scope_info_counter_bits-1:0] LAST_IDX =
    scope_info_counter_bits'(scope_info_bytes - 1);

  state_t                              state_q, state_d;
  logic [scope_info_counter_bits-1:0]  index_q, index_d;
  logic [FLAT_W-1:0]                   snap_q, snap_d;
  logic                                error_q, error_d;
  logic                                ack_tc;
  logic [scope_info_bits_per_byte-1:0] byte_sel, out_byte;

  // Timer runs only while a byte is offered; leaving ISSUE or an ack zeroes it.
  scope_ack_timer #(
    .ack_timeout_bits(ack_timeout_bits)
  ) u_ack_timer (
    .sm_clk(sm_clk),
    .reset (reset),
    .clr   ((state_q != ISSUE) | lcd_ack),
    .en    (state_q == ISSUE),
    .tc    (ack_tc)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    snap_d  = snap_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          state_d = SNAPSHOT;
        end
      end
      SNAPSHOT: begin
        snap_d  = scope_info_flat;
        index_d = LAST_IDX;
        state_d = ISSUE;
      end
      ISSUE: begin
        // Ack checked first: it beats a coincident timeout.
        if (lcd_ack)
          state_d = GAP;
        else if (ack_tc) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      GAP: begin
        // One cycle with req low so a held ack cannot accept two bytes.
        if (index_q == '0)
          state_d = DONE;
        else begin
          index_d = index_q - 1'b1;
          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sm_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      index_q <= '0;
      snap_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      snap_q  <= snap_d;
      error_q <= error_d;
    end
  end

  assign byte_sel = snap_q[int'(index_q)*scope_info_bits_per_byte +: scope_info_bits_per_byte];

`ifdef SCOPE_READER_NULL_TO_SPACE_EN
  assign out_byte = (byte_sel == '0) ? scope_info_bits_per_byte'(ASCII_SPACE) : byte_sel;
`else
  assign out_byte = byte_sel;
`endif

  // Outputs decode registered state, so they are stable for the whole ISSUE
  // and fall to their reset values on the same edge that takes reset.
  assign lcd_req  = (state_q == ISSUE);
  assign lcd_data = lcd_req ? out_byte : '0;
  assign lcd_addr = lcd_req ? (LAST_IDX - index_q) : '0;
  assign busy     = (state_q != IDLE);
  assign finish   = (state_q == DONE);
  assign error    = error_q;
  assign debug    = {7'b0, error_q, 4'(index_q), state_q};

endmodule

// File: tb/tb_scope_lcd_byte_reader.sv
module tb_scope_lcd_byte_reader;

  localparam logic [127:0] HELLO = "HELLO WORLD 1234";

  logic         sm_clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] scope_info_flat = '0;
  logic         lcd_ack = 1'b0;
  logic         lcd_req, busy, finish, error;
  logic [7:0]   lcd_data;
  logic [3:0]   lcd_addr;
  logic [15:0]  debug;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_mode = 0;   // 0: never ack, 1: ack one cycle after req, 2: ack held high
  int req_cnt  = 0;

  // monitor state (written only by the monitor process)
  int         clear_tok = 0;
  int         seen_tok = 0;
  logic [7:0] wr_data[$];
  logic [3:0] wr_addr[$];
  int         finish_cnt = 0, req_rises = 0, req_hi = 0, low_run = 0;
  int         gap_bad = 0, addr_nonzero = 0;
  logic       prev_req = 1'b0;

  scope_lcd_byte_reader #(
    .scope_info_bytes        (16),
    .scope_info_bits_per_byte(8),
    .scope_info_counter_bits (4),
    .ack_timeout_bits        (4)
  ) dut (
    .sm_clk         (sm_clk),
    .reset          (reset),
    .start          (start),
    .scope_info_flat(scope_info_flat),
    .lcd_ack        (lcd_ack),
    .lcd_req        (lcd_req),
    .lcd_data       (lcd_data),
    .lcd_addr       (lcd_addr),
    .busy           (busy),
    .finish         (finish),
    .error          (error),
    .debug          (debug)
  );

  always #5 sm_clk = ~sm_clk;

  // LCD-side responder
  always @(posedge sm_clk) begin
    #1;
    if (lcd_req) req_cnt++; else req_cnt = 0;
    case (ack_mode)
      0:       lcd_ack = 1'b0;
      1:       lcd_ack = (req_cnt >= 2);
      default: lcd_ack = 1'b1;
    endcase
  end

  // Monitor: a byte counts when req&ack are seen before the accepting edge.
  always @(negedge sm_clk) begin
    if (seen_tok != clear_tok) begin
      seen_tok = clear_tok;
      wr_data.delete();
      wr_addr.delete();
      finish_cnt = 0; req_rises = 0; req_hi = 0; low_run = 0;
      gap_bad = 0; addr_nonzero = 0; prev_req = 1'b0;
    end
    if (reset && lcd_req && lcd_ack) begin
      wr_data.push_back(lcd_data);
      wr_addr.push_back(lcd_addr);
    end
    if (lcd_req) begin
      req_hi++;
      if (!prev_req) begin
        req_rises++;
        if (req_rises > 1 && low_run != 1) gap_bad++;
      end
      low_run = 0;
      if (lcd_addr != 4'd0) addr_nonzero++;
    end else begin
      low_run++;
    end
    prev_req = lcd_req;
    if (finish) finish_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sm_clk);
    #1;
  endtask

  task automatic begin_frame(input int mode);
    ack_mode = mode;
    clear_tok++;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    int n = 0;
    while (finish_cnt == 0 && n < 400) begin
      step();
      n++;
    end
    chk({tag, " finish seen"}, 32'(finish_cnt != 0), 1);
  endtask

  task automatic check_stream(input string tag, input logic [127:0] exp);
    chk({tag, " writes"}, wr_data.size(), 16);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = exp[(15-i)*8 +: 8];
`ifdef SCOPE_READER_NULL_TO_SPACE_EN
      if (b == 8'h00) b = 8'h20;
`endif
      if (i < wr_data.size()) begin
        chk($sformatf("%s data%0d", tag, i), 32'(wr_data[i]), 32'(b));
        chk($sformatf("%s addr%0d", tag, i), 32'(wr_addr[i]), i);
      end
    end
    chk({tag, " finish count"}, finish_cnt, 1);
    chk({tag, " req rises"}, req_rises, 16);
    chk({tag, " gap len"}, gap_bad, 0);
    chk({tag, " error"}, 32'(error), 0);
    chk({tag, " busy after"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [127:0] tmp;
    int n;

    // reset state
    repeat (3) step();
    chk("rst req", 32'(lcd_req), 0);
    chk("rst data", 32'(lcd_data), 0);
    chk("rst addr", 32'(lcd_addr), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst finish", 32'(finish), 0);
    chk("rst error", 32'(error), 0);
    chk("rst debug", 32'(debug), 0);
    reset = 1'b1;
    step();

    // full frame, ack one cycle after req
    scope_info_flat = HELLO;
    begin_frame(1);
    chk("t1 snapshot state", 32'(debug[3:0]), 1);
    chk("t1 req during snapshot", 32'(lcd_req), 0);
    step();
    chk("t1 first req", 32'(lcd_req), 1);
    chk("t1 first addr", 32'(lcd_addr), 0);
    chk("t1 first data", 32'(lcd_data), 32'h48);
    wait_finish("t1");
    check_stream("t1", HELLO);

    // input changes after the snapshot do not leak into the frame
    begin_frame(1);
    step();
    scope_info_flat = {16{8'h41}};
    wait_finish("t2");
    check_stream("t2", HELLO);
    scope_info_flat = HELLO;

    // ack never arrives: abort after 15 ISSUE cycles
    begin_frame(0);
    wait_finish("t3");
    chk("t3 writes", wr_data.size(), 0);
    chk("t3 issue cycles", req_hi, 15);
    chk("t3 req rises", req_rises, 1);
    chk("t3 addr only 0", addr_nonzero, 0);
    chk("t3 finish count", finish_cnt, 1);
    chk("t3 error", 32'(error), 1);
    chk("t3 busy", 32'(busy), 0);
    chk("t3 debug", 32'(debug), 32'h01F0);

    // held ack plus a start while busy
    begin_frame(2);
    n = 0;
    while (!(wr_data.size() == 5 && lcd_req) && n < 200) begin
      step();
      n++;
    end
    chk("t4 reached byte 5", 32'(wr_data.size() == 5 && lcd_req), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_finish("t4");
    check_stream("t4", HELLO);
    repeat (4) step();
    chk("t4 no restart busy", 32'(busy), 0);
    chk("t4 no restart finish", finish_cnt, 1);
    ack_mode = 0;

    // reset mid-frame at index 7
    begin_frame(1);
    n = 0;
    while (!(debug[7:4] == 4'd7 && lcd_req) && n < 200) begin
      step();
      n++;
    end
    chk("t5 reached index 7", 32'(debug[7:4] == 4'd7 && lcd_req), 1);
    reset = 1'b0;
    step();
    chk("t5 req after reset", 32'(lcd_req), 0);
    chk("t5 busy after reset", 32'(busy), 0);
    chk("t5 debug after reset", 32'(debug), 0);
    reset = 1'b1;
    step();
    chk("t5 no finish", finish_cnt, 0);
    begin_frame(1);
    wait_finish("t5");
    check_stream("t5", HELLO);

    // null byte at index 3 (column 12)
    tmp = HELLO;
    tmp[31:24] = 8'h00;
    scope_info_flat = tmp;
    begin_frame(1);
    wait_finish("t6");
    check_stream("t6", tmp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
